// File: rtl/apb_master_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_bridge_pkg
// Description : Shared types and default widths for the req/gnt/rvalid to
//               APB3 master bridge: FSM state encoding, default bus widths
//               and the request record captured on acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_bridge_pkg;

    localparam int unsigned c_apb_addr_width = 32;
    localparam int unsigned c_apb_data_width = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Request record at the default widths.
    typedef struct packed {
        logic [c_apb_addr_width-1:0] addr;
        logic                        we;
        logic [c_apb_data_width-1:0] wdata;
    } apb_req_t;

endpackage
`default_nettype wire

// File: rtl/apb_master_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_req_if / apb_if
// Description : Bus bundles for the bridge.
//               apb_req_if - upstream single-outstanding request bus
//                 req_i, addr_i, we_i, wdata_i  : requester -> bridge
//                 gnt_o, rvalid_o, rdata_o, err_o : bridge -> requester
//               apb_if     - APB3 master port
//                 psel_o, penable_o, pwrite_o, paddr_o, pwdata_o : bridge -> node
//                 prdata_i, pready_i, pslverr_i                  : node -> bridge
//               Signal names keep the bridge's port naming so the direction
//               suffix is always relative to the bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_req_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();
    logic          req_i;
    logic          gnt_o;
    logic [AW-1:0] addr_i;
    logic          we_i;
    logic [DW-1:0] wdata_i;
    logic          rvalid_o;
    logic [DW-1:0] rdata_o;
    logic          err_o;

    // Requester side.
    modport master (
        output req_i, addr_i, we_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    // Bridge side.
    modport slave (
        input  req_i, addr_i, we_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

interface apb_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();
    logic          psel_o;
    logic          penable_o;
    logic          pwrite_o;
    logic [AW-1:0] paddr_o;
    logic [DW-1:0] pwdata_o;
    logic [DW-1:0] prdata_i;
    logic          pready_i;
    logic          pslverr_i;

    // Bridge side.
    modport master (
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
        input  prdata_i, pready_i, pslverr_i
    );

    // APB node side.
    modport slave (
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
        output prdata_i, pready_i, pslverr_i
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_bridge_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : apb_timeout_cnt
// Description : ACCESS-phase wait counter. Cleared on entry to ACCESS,
//               advances on every stalled ACCESS cycle and flags expiry once
//               the count reaches TIMEOUT_CYCLES-1.
//   clk       in  clock
//   rst       in  synchronous active-high reset
//   i_clear   in  restart the count (asserted in the cycle before ACCESS)
//   i_enable  in  count one stalled cycle
//   o_expired out count has reached TIMEOUT_CYCLES-1
// Revision    : 1.0 - initial release
// ============================================================================
module apb_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expired
);

    localparam int unsigned c_cnt_w = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_cnt_w-1:0] r_count;

    // Saturates at the expiry value so a held enable cannot wrap the count.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

    assign o_expired = (r_count == c_cnt_w'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_bridge
// Description : Converts a single-outstanding req/gnt/rvalid bus into APB3
//               master transfers (IDLE -> SETUP -> ACCESS), returning one
//               registered response pulse per accepted request.
//   clk_i    in  clock
//   rst_i    in  synchronous active-high reset
//   req_bus  apb_req_if.slave : req/gnt/addr/we/wdata, rvalid/rdata/err
//   apb_bus  apb_if.master    : psel/penable/pwrite/paddr/pwdata,
//                               prdata/pready/pslverr
// Build option: define APB_BRIDGE_TIMEOUT_EN to abort an ACCESS phase that
//               stalls for TIMEOUT_CYCLES cycles with an error response.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_bridge
    import apb_bridge_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = c_apb_addr_width,
    parameter int unsigned APB_DATA_WIDTH = c_apb_data_width,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  wire logic  clk_i,
    input  wire logic  rst_i,
    apb_req_if.slave   req_bus,
    apb_if.master      apb_bus
);

    typedef struct packed {
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic                      we;
        logic [APB_DATA_WIDTH-1:0] wdata;
    } req_t;

    apb_state_e                r_state;
    req_t                      r_req;
    logic                      r_gnt;
    logic                      r_psel;
    logic                      r_penable;
    logic                      r_rvalid;
    logic [APB_DATA_WIDTH-1:0] r_rdata;
    logic                      r_err;
    logic                      w_timeout;

`ifdef APB_BRIDGE_TIMEOUT_EN
    apb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk       (clk_i),
        .rst       (rst_i),
        .i_clear   (r_state == SETUP),
        .i_enable  ((r_state == ACCESS) && !apb_bus.pready_i),
        .o_expired (w_timeout)
    );
`else
    // No counter in this build: the comparison is constant false for any
    // legal TIMEOUT_CYCLES, so ACCESS waits for pready_i indefinitely.
    assign w_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_req     <= '0;
            r_gnt     <= 1'b1;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            // Response is a single-cycle pulse; data/error read as 0 otherwise.
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_bus.req_i) begin
                        r_state   <= SETUP;
                        r_gnt     <= 1'b0;
                        r_psel    <= 1'b1;
                        r_req     <= '{addr:  req_bus.addr_i,
                                       we:    req_bus.we_i,
                                       wdata: req_bus.wdata_i};
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    // pready_i wins over a timeout expiring in the same cycle.
                    if (apb_bus.pready_i || w_timeout) begin
                        r_state   <= IDLE;
                        r_gnt     <= 1'b1;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_req     <= '0;
                        r_rvalid  <= 1'b1;
                        r_err     <= apb_bus.pready_i ? apb_bus.pslverr_i : 1'b1;
                        r_rdata   <= (apb_bus.pready_i && !r_req.we) ? apb_bus.prdata_i : '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= 1'b1;
                end
            endcase
        end
    end

    assign req_bus.gnt_o    = r_gnt;
    assign req_bus.rvalid_o = r_rvalid;
    assign req_bus.rdata_o  = r_rdata;
    assign req_bus.err_o    = r_err;

    // Request fields are cleared on return to IDLE, so the APB address and
    // data lines idle at 0 and hold steady from SETUP through ACCESS.
    assign apb_bus.psel_o    = r_psel;
    assign apb_bus.penable_o = r_penable;
    assign apb_bus.pwrite_o  = r_req.we;
    assign apb_bus.paddr_o   = r_req.addr;
    assign apb_bus.pwdata_o  = r_req.wdata;

endmodule
`default_nettype wire
